// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a bubble/hold FSM, a stall watchdog and
// instruction/bubble counters.
//
// Ports:
//   Clock, Reset       rising-edge clock, synchronous active-high reset
//   PCIn, PCPlus4In    fetch address and its +4 value from the IF stage
//   InstructionIn      instruction memory read data for PCIn
//   Stall, Flush       hazard-unit hold request, EX squash request
//   PCWriteEnable      combinational program counter write enable
//   InstructionOut     registered instruction (NOP_WORD on a bubble)
//   PCOut, PCPlus4Out  registered fetch address and PC+4
//   ValidOut           InstructionOut is a real instruction
//   StallError         sticky flag, stall run exceeded STALL_LIMIT
//   InstrCount         valid instructions accepted (wraps)
//   BubbleCount        bubbles inserted by Flush (saturates)
module if_id_stage #(
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] PCIn,
    input  logic [31:0] PCPlus4In,
    input  logic [31:0] InstructionIn,
    input  logic        Stall,
    input  logic        Flush,
    output logic        PCWriteEnable,
    output logic [31:0] InstructionOut,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus4Out,
    output logic        ValidOut,
    output logic        StallError,
    output logic [31:0] InstrCount,
    output logic [15:0] BubbleCount
);

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        HOLD
    } state_t;

    // Declaration initialisers give the reset values at time zero in
    // simulation, before the first reset edge.
    state_t      state_q = EMPTY;
    state_t      state_d;
    logic [31:0] instr_q = NOP_WORD;
    logic [31:0] instr_d;
    logic [31:0] pc_q    = 32'h0;
    logic [31:0] pc_d;
    logic [31:0] pc4_q   = 32'h0;
    logic [31:0] pc4_d;
    logic [31:0] icnt_q  = 32'h0;
    logic [31:0] icnt_d;
    logic [15:0] bcnt_q  = 16'h0;
    logic [15:0] bcnt_d;
    logic [3:0]  run_q   = 4'h0;
    logic [3:0]  run_d;
    logic        err_q   = 1'b0;
    logic        err_d;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        icnt_d  = icnt_q;
        bcnt_d  = bcnt_q;
        run_d   = run_q;
        err_d   = err_q;

        if (Reset) begin
            state_d = EMPTY;
            instr_d = NOP_WORD;
            pc_d    = 32'h0;
            pc4_d   = 32'h0;
            icnt_d  = 32'h0;
            bcnt_d  = 16'h0;
            run_d   = 4'h0;
            err_d   = 1'b0;
        end else if (Flush) begin
            state_d = EMPTY;
            instr_d = NOP_WORD;
            pc_d    = 32'h0;
            pc4_d   = 32'h0;
            run_d   = 4'h0;
            if (bcnt_q != 16'hFFFF) begin
                bcnt_d = bcnt_q + 16'd1;
            end
        end else if (Stall) begin
            // A bubble stays a bubble while held; a real instruction
            // moves to HOLD.
            state_d = (state_q == EMPTY) ? EMPTY : HOLD;
            if (run_q != 4'hF) begin
                run_d = run_q + 4'd1;
            end
            // Flag the stall that would take the run past the limit.
            if ((32'(run_q) + 32'd1) > STALL_LIMIT) begin
                err_d = 1'b1;
            end
        end else begin
            state_d = FULL;
            instr_d = InstructionIn;
            pc_d    = PCIn;
            pc4_d   = PCPlus4In;
            icnt_d  = icnt_q + 32'd1;
            run_d   = 4'h0;
        end
    end

    always_ff @(posedge Clock) begin
        state_q <= state_d;
        instr_q <= instr_d;
        pc_q    <= pc_d;
        pc4_q   <= pc4_d;
        icnt_q  <= icnt_d;
        bcnt_q  <= bcnt_d;
        run_q   <= run_d;
        err_q   <= err_d;
    end

    assign PCWriteEnable  = Reset | ~(Stall & ~Flush);
    assign InstructionOut = instr_q;
    assign PCOut          = pc_q;
    assign PCPlus4Out     = pc4_q;
    assign ValidOut       = (state_q != EMPTY);
    assign StallError     = err_q;
    assign InstrCount     = icnt_q;
    assign BubbleCount    = bcnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_if_id_stage;

    logic        Clock;
    logic        Reset;
    logic [31:0] PCIn;
    logic [31:0] PCPlus4In;
    logic [31:0] InstructionIn;
    logic        Stall;
    logic        Flush;
    logic        PCWriteEnable;
    logic [31:0] InstructionOut;
    logic [31:0] PCOut;
    logic [31:0] PCPlus4Out;
    logic        ValidOut;
    logic        StallError;
    logic [31:0] InstrCount;
    logic [15:0] BubbleCount;

    int passed = 0;
    int total  = 0;

    if_id_stage dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .PCIn          (PCIn),
        .PCPlus4In     (PCPlus4In),
        .InstructionIn (InstructionIn),
        .Stall         (Stall),
        .Flush         (Flush),
        .PCWriteEnable (PCWriteEnable),
        .InstructionOut(InstructionOut),
        .PCOut         (PCOut),
        .PCPlus4Out    (PCPlus4Out),
        .ValidOut      (ValidOut),
        .StallError    (StallError),
        .InstrCount    (InstrCount),
        .BubbleCount   (BubbleCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
        PCIn          = pc;
        PCPlus4In     = pc + 32'd4;
        InstructionIn = ins;
    endtask

    initial begin
        Reset = 1'b1;
        Stall = 1'b0;
        Flush = 1'b0;
        drive(32'h0, 32'h0);

        // Time-zero values before any edge.
        #1;
        chk("t0_valid", 32'(ValidOut), 32'd0);
        chk("t0_pc", PCOut, 32'h0);
        chk("t0_instr", InstructionOut, 32'h0);

        // Reset forces PC write even with Stall high.
        Stall = 1'b1;
        #1;
        chk("rst_pcwe", 32'(PCWriteEnable), 32'd1);
        step();
        chk("rst_valid", 32'(ValidOut), 32'd0);
        chk("rst_instr", InstructionOut, 32'h0);
        chk("rst_pc4", PCPlus4Out, 32'h0);
        chk("rst_icnt", InstrCount, 32'd0);
        chk("rst_bcnt", 32'(BubbleCount), 32'd0);
        chk("rst_err", 32'(StallError), 32'd0);

        // Three back-to-back loads.
        Reset = 1'b0;
        Stall = 1'b0;
        drive(32'h0, 32'hAAAA_0001);
        #1;
        chk("ld_pcwe", 32'(PCWriteEnable), 32'd1);
        step();
        chk("ldA_instr", InstructionOut, 32'hAAAA_0001);
        chk("ldA_pc", PCOut, 32'h0);
        chk("ldA_pc4", PCPlus4Out, 32'h4);
        chk("ldA_valid", 32'(ValidOut), 32'd1);
        drive(32'h4, 32'hBBBB_0002);
        step();
        chk("ldB_instr", InstructionOut, 32'hBBBB_0002);
        chk("ldB_pc", PCOut, 32'h4);
        drive(32'h8, 32'hCCCC_0003);
        step();
        chk("ldC_instr", InstructionOut, 32'hCCCC_0003);
        chk("ldC_pc", PCOut, 32'h8);
        chk("ldC_icnt", InstrCount, 32'd3);

        // Stall and Flush together act as Flush.
        Stall = 1'b1;
        Flush = 1'b1;
        drive(32'hC, 32'hDEAD_BEEF);
        #1;
        chk("sf_pcwe", 32'(PCWriteEnable), 32'd1);
        step();
        chk("sf_valid", 32'(ValidOut), 32'd0);
        chk("sf_instr", InstructionOut, 32'h0);
        chk("sf_pc", PCOut, 32'h0);
        chk("sf_pc4", PCPlus4Out, 32'h0);
        chk("sf_bcnt", 32'(BubbleCount), 32'd1);
        chk("sf_icnt", InstrCount, 32'd3);

        // Load D at 4, hold it two cycles, then release.
        Stall = 1'b0;
        Flush = 1'b0;
        drive(32'h4, 32'hDDDD_0004);
        step();
        chk("ldD_pc", PCOut, 32'h4);
        chk("ldD_icnt", InstrCount, 32'd4);
        Stall = 1'b1;
        drive(32'h8, 32'hEEEE_0005);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_pcwe", 32'(PCWriteEnable), 32'd0);
            step();
            chk("hold_pc", PCOut, 32'h4);
            chk("hold_instr", InstructionOut, 32'hDDDD_0004);
            chk("hold_valid", 32'(ValidOut), 32'd1);
        end
        Stall = 1'b0;
        step();
        chk("rel_pc", PCOut, 32'h8);
        chk("rel_instr", InstructionOut, 32'hEEEE_0005);
        chk("rel_icnt", InstrCount, 32'd5);

        // Sixteen consecutive stalls trip the watchdog on the 16th edge.
        Stall = 1'b1;
        drive(32'hC, 32'hFFFF_0006);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) chk("wd_err15", 32'(StallError), 32'd0);
            if (i == 16) chk("wd_err16", 32'(StallError), 32'd1);
        end
        chk("wd_icnt", InstrCount, 32'd5);
        Stall = 1'b0;
        step();
        chk("wdrel_instr", InstructionOut, 32'hFFFF_0006);
        chk("wdrel_icnt", InstrCount, 32'd6);
        chk("wdrel_err", 32'(StallError), 32'd1);
        Flush = 1'b1;
        step();
        chk("wdfl_bcnt", 32'(BubbleCount), 32'd2);
        chk("wdfl_err", 32'(StallError), 32'd1);
        chk("wdfl_valid", 32'(ValidOut), 32'd0);
        Flush = 1'b0;

        // Stall while EMPTY keeps the bubble.
        Stall = 1'b1;
        drive(32'h10, 32'h1111_0007);
        #1;
        chk("emp_pcwe", 32'(PCWriteEnable), 32'd0);
        step();
        step();
        chk("emp_valid", 32'(ValidOut), 32'd0);
        chk("emp_instr", InstructionOut, 32'h0);
        chk("emp_icnt", InstrCount, 32'd6);
        Stall = 1'b0;
        step();
        chk("ldG_instr", InstructionOut, 32'h1111_0007);
        chk("ldG_icnt", InstrCount, 32'd7);

        // Reset during HOLD with a coincident Flush.
        Stall = 1'b1;
        step();
        chk("hold2_valid", 32'(ValidOut), 32'd1);
        Reset = 1'b1;
        Flush = 1'b1;
        #1;
        chk("rst2_pcwe", 32'(PCWriteEnable), 32'd1);
        step();
        chk("rst2_valid", 32'(ValidOut), 32'd0);
        chk("rst2_pc", PCOut, 32'h0);
        chk("rst2_instr", InstructionOut, 32'h0);
        chk("rst2_icnt", InstrCount, 32'd0);
        chk("rst2_bcnt", 32'(BubbleCount), 32'd0);
        chk("rst2_err", 32'(StallError), 32'd0);

        // First load after reset, then a wrapping PC value.
        Reset = 1'b0;
        Stall = 1'b0;
        Flush = 1'b0;
        drive(32'h14, 32'h2222_0008);
        step();
        chk("ldH_instr", InstructionOut, 32'h2222_0008);
        chk("ldH_pc", PCOut, 32'h14);
        chk("ldH_icnt", InstrCount, 32'd1);
        chk("ldH_valid", 32'(ValidOut), 32'd1);
        drive(32'hFFFF_FFFC, 32'h3333_0009);
        step();
        chk("wrap_pc", PCOut, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4Out, 32'h0);
        chk("wrap_icnt", InstrCount, 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
